wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writers: the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- Pipeline writes have priority. MDU results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation counter forces a one-cycle pipeline stall so buffered results always retire.
- The block also exports a pending-rd mask for the hazard unit. It sits between the writeback stage / MDU and the register file.

---
 rtl/core_pkg.sv | 17 +
 rtl/wb_result_fifo.sv | 65 ++++++
 rtl/wb_port_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the register-file write-port arbiter: a write request
// (destination register plus data) and the architectural zero register.
package core_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // One-hot decode of a destination register, used to build the pending mask.
   function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
      return 32'd1 << rd;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of MDU results waiting for an idle write-port cycle.
// Exposes per-slot occupancy and destination registers so the top can build the pending mask.
module wb_result_fifo
   import core_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  wb_req_t               push_data_i,
   input  logic                  pop_i,
   output wb_req_t               head_o,
   output logic [CW-1:0]         count_o,
   output logic [DEPTH-1:0]      valid_o,
   output logic [DEPTH-1:0][4:0] entry_rd_o
);

   wb_req_t         entries_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;

   // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            entries_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q            <= wr_ptr_q + PW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      logic [PW-1:0] off;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off           = PW'(i) - rd_ptr_q;
         valid_o[i]    = (CW'(off) < count_q);
         entry_rd_o[i] = entries_q[i].rd;
      end
   end

   assign head_o  = entries_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the writeback stage (priority) and
// buffered MDU results, with a starvation stall so buffered results always retire.
module wb_port_arbiter
   import core_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_write_data,
   input  logic        wb_wr_enable,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_write_data,
   output logic        rf_wr_enable,
   output logic        stall_pipe,
   output logic [31:0] pending_mask
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(STARVE_LIMIT + 1);

   wb_req_t               head_s;
   logic [CW-1:0]         count_s;
   logic [DEPTH-1:0]      valid_s;
   logic [DEPTH-1:0][4:0] entry_rd_s;
   logic                  empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  blocked_s;

   logic [4:0]    rf_rd_q,   rf_rd_d;
   logic [31:0]   rf_data_q, rf_data_d;
   logic          rf_en_q,   rf_en_d;
   logic          stall_q,   stall_d;
   logic [WW-1:0] wait_q,    wait_d;

   assign empty_s   = (count_s == CW'(0));
   assign mdu_ready = (count_s < CW'(DEPTH));
   assign push_s    = mdu_valid && mdu_ready;

   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_s),
      .push_data_i ({mdu_rd, mdu_data}),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .count_o     (count_s),
      .valid_o     (valid_s),
      .entry_rd_o  (entry_rd_s)
   );

   // Grant: pipeline first unless a forced stall hands the port to the FIFO head.
   always_comb begin
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
      rf_en_d   = 1'b0;
      pop_s     = 1'b0;
      if (wb_wr_enable && !stall_q) begin
         rf_rd_d   = wb_rd;
         rf_data_d = wb_write_data;
         rf_en_d   = (wb_rd != REG_ZERO);
      end else if (!empty_s) begin
         pop_s     = 1'b1;
         rf_rd_d   = head_s.rd;
         rf_data_d = head_s.data;
         rf_en_d   = (head_s.rd != REG_ZERO);
      end else begin
         rf_en_d   = 1'b0;
      end
   end

   // Starvation tracking: the stall is raised on the STARVE_LIMIT-th blocked cycle.
   always_comb begin
      blocked_s = !empty_s && !pop_s;
      if (blocked_s) begin
         wait_d  = wait_q + WW'(1);
         stall_d = (wait_q == WW'(STARVE_LIMIT - 1));
      end else begin
         wait_d  = '0;
         stall_d = 1'b0;
      end
   end

   // Hazard mask of every destination still buffered; r0 is never a hazard.
   always_comb begin
      pending_mask = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_s[i]) begin
            pending_mask = pending_mask | rd_onehot(entry_rd_s[i]);
         end else begin
            pending_mask = pending_mask;
         end
      end
      pending_mask[0] = 1'b0;
   end

   // Registered write-port outputs and starvation state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_rd_q   <= 5'd0;
         rf_data_q <= 32'd0;
         rf_en_q   <= 1'b0;
         stall_q   <= 1'b0;
         wait_q    <= '0;
      end else begin
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
         rf_en_q   <= rf_en_d;
         stall_q   <= stall_d;
         wait_q    <= wait_d;
      end
   end

   assign rf_rd         = rf_rd_q;
   assign rf_write_data = rf_data_q;
   assign rf_wr_enable  = rf_en_q;
   assign stall_pipe    = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference predicts each
// cycle's port grant, and the prediction is compared one edge later.
module tb_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  wb_rd;
   logic [31:0] wb_write_data;
   logic        wb_wr_enable;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic [4:0]  rf_rd;
   logic [31:0] rf_write_data;
   logic        rf_wr_enable;
   logic        stall_pipe;
   logic [31:0] pending_mask;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_rd         (wb_rd),
      .wb_write_data (wb_write_data),
      .wb_wr_enable  (wb_wr_enable),
      .mdu_valid     (mdu_valid),
      .mdu_ready     (mdu_ready),
      .mdu_rd        (mdu_rd),
      .mdu_data      (mdu_data),
      .rf_rd         (rf_rd),
      .rf_write_data (rf_write_data),
      .rf_wr_enable  (rf_wr_enable),
      .stall_pipe    (stall_pipe),
      .pending_mask  (pending_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        stall;
   } exp_t;

   ent_t        mq[$];
   exp_t        sb[$];
   int          mwait;
   logic        mstall;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        last_push;
   int          checks   = 0;
   int          failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = 32'd0;
      foreach (mq[i]) m[mq[i].rd] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   task automatic model_clear();
      mq.delete();
      sb.delete();
      mwait  = 0;
      mstall = 1'b0;
      m_rd   = 5'd0;
      m_data = 32'd0;
   endtask

   // One clock: apply hazard/stall contracts, predict, advance, compare.
   task automatic cycle();
      logic        do_push, do_pop, blocked;
      logic [31:0] mm;
      exp_t        e;
      ent_t        h;
      #1;
      mm = model_mask();
      if (mstall) wb_wr_enable = 1'b0;
      if (wb_wr_enable && mm[wb_rd]) wb_wr_enable = 1'b0;
      #1;
      check_eq("mdu_ready", mdu_ready, (mq.size() < DEPTH));
      check_eq("pending_mask", pending_mask, mm);
      if (wb_wr_enable) check_eq("hazard", pending_mask[wb_rd] && (wb_rd != 5'd0), 1'b0);
      if (stall_pipe) check_eq("stall_wb", wb_wr_enable, 1'b0);

      do_push = mdu_valid && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && (mstall || !wb_wr_enable);
      if (wb_wr_enable && !mstall) begin
         m_rd   = wb_rd;
         m_data = wb_write_data;
         e.en   = (wb_rd != 5'd0);
      end else if (do_pop) begin
         h      = mq[0];
         m_rd   = h.rd;
         m_data = h.data;
         e.en   = (h.rd != 5'd0);
      end else begin
         e.en   = 1'b0;
      end
      e.rd    = m_rd;
      e.data  = m_data;
      blocked = (mq.size() > 0) && !do_pop;
      e.stall = blocked && (mwait == LIMIT - 1);
      mwait   = blocked ? mwait + 1 : 0;
      mstall  = e.stall;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{mdu_rd, mdu_data});
      last_push = do_push;
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("rf_wr_enable", rf_wr_enable, e.en);
      if (e.en) begin
         check_eq("rf_rd", rf_rd, e.rd);
         check_eq("rf_write_data", rf_write_data, e.data);
      end
      check_eq("stall_pipe", stall_pipe, e.stall);
   endtask

   task automatic idle_inputs();
      wb_wr_enable  = 1'b0;
      wb_rd         = 5'd0;
      wb_write_data = 32'd0;
      mdu_valid     = 1'b0;
      mdu_rd        = 5'd0;
      mdu_data      = 32'd0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_rf_en"}, rf_wr_enable, 1'b0);
      check_eq({tag, "_rf_rd"}, rf_rd, 5'd0);
      check_eq({tag, "_rf_data"}, rf_write_data, 32'd0);
      check_eq({tag, "_stall"}, stall_pipe, 1'b0);
      check_eq({tag, "_ready"}, mdu_ready, 1'b1);
      check_eq({tag, "_pending"}, pending_mask, 32'd0);
   endtask

   initial begin
      int   k;
      int   first_stall;
      logic saw_not_ready;

      rst_n = 1'b0;
      idle_inputs();
      model_clear();
      #12;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pipeline-only writes, including r0.
      wb_wr_enable = 1'b1; wb_rd = 5'd5; wb_write_data = 32'h0000_1234;
      cycle();
      check_eq("pipe_rd5", {rf_wr_enable, rf_rd, rf_write_data}, {1'b1, 5'd5, 32'h0000_1234});
      wb_wr_enable = 1'b1; wb_rd = 5'd0; wb_write_data = 32'h0000_0055;
      cycle();
      check_eq("pipe_rd0_en", rf_wr_enable, 1'b0);

      // Idle-port drain: two-cycle latency, pending for one cycle.
      idle_inputs();
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_DEAD;
      cycle();
      mdu_valid = 1'b0;
      check_eq("drain_pending7", pending_mask[7], 1'b1);
      cycle();
      check_eq("drain_write", {rf_wr_enable, rf_rd, rf_write_data}, {1'b1, 5'd7, 32'h0000_DEAD});
      check_eq("drain_pending_clear", pending_mask[7], 1'b0);

      // Fill and backpressure under continuous pipeline writes.
      k = 0;
      saw_not_ready = 1'b0;
      for (int c = 0; c < 20 && k < 3; c++) begin
         wb_wr_enable = 1'b1; wb_rd = 5'(20 + c % 8); wb_write_data = $urandom;
         mdu_valid = 1'b1; mdu_rd = 5'(10 + k); mdu_data = 32'hA000 + 32'(k);
         if (!mdu_ready) saw_not_ready = 1'b1;
         cycle();
         if (last_push) k++;
      end
      check_eq("fill_accepted", k, 3);
      check_eq("fill_backpressure", saw_not_ready, 1'b1);
      idle_inputs();
      for (int c = 0; c < 6; c++) cycle();

      // Starvation: rd 9 blocked by continuous pipeline writes.
      wb_wr_enable = 1'b1; wb_rd = 5'd3; wb_write_data = 32'h0000_0003;
      mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h0000_0909;
      cycle();
      mdu_valid = 1'b0;
      first_stall = -1;
      for (int i = 1; i <= 8; i++) begin
         wb_wr_enable = 1'b1; wb_rd = 5'd3; wb_write_data = 32'(i);
         cycle();
         if (stall_pipe && first_stall < 0) first_stall = i;
         if (i == 5) check_eq("starve_drain", {rf_wr_enable, rf_rd}, {1'b1, 5'd9});
         if (i == 6) check_eq("starve_resume", {rf_wr_enable, rf_rd}, {1'b1, 5'd3});
      end
      check_eq("starve_cycle", first_stall, 4);

      // Simultaneous push/pop at count 1, then an r0 MDU result.
      idle_inputs();
      mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'h0000_0C0C;
      cycle();
      mdu_rd = 5'd13; mdu_data = 32'h0000_0D0D;
      cycle();
      check_eq("pp_head_written", {rf_wr_enable, rf_rd}, {1'b1, 5'd12});
      check_eq("pp_new_head", pending_mask, 32'h0000_2000);
      mdu_rd = 5'd0; mdu_data = 32'h0000_FFFF;
      cycle();
      mdu_valid = 1'b0;
      cycle();
      check_eq("r0_consumed", rf_wr_enable, 1'b0);
      cycle();

      // Random traffic under the hazard/stall contracts.
      for (int c = 0; c < 300; c++) begin
         wb_wr_enable  = 1'($urandom_range(0, 1));
         wb_rd         = 5'($urandom_range(0, 31));
         wb_write_data = $urandom;
         mdu_valid     = 1'($urandom_range(0, 1));
         mdu_rd        = 5'($urandom_range(0, 31));
         mdu_data      = $urandom;
         cycle();
      end

      // Reset mid-operation with the FIFO full and a stall pending.
      for (int c = 0; c < 30 && !mstall; c++) begin
         wb_wr_enable = 1'b1; wb_rd = 5'd30; wb_write_data = 32'(c);
         mdu_valid = 1'b1; mdu_rd = 5'(14 + c % 2); mdu_data = 32'hB000 + 32'(c);
         cycle();
      end
      check_eq("pre_rst_stall", stall_pipe, 1'b1);
      check_eq("pre_rst_full", mdu_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      idle_inputs();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
